// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) to single memory port arbiter; 1 outstanding txn, min 3 cycles handshake-to-handshake,
// requesters stalled (ready=0) while busy. Define MEM_ARB_RR_EN for round-robin, else fixed LSU-first.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;  // 1 = LSU owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              grant_lsu, grant_ifu, hs, in_req, resp_fire;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;  // 1 = LSU granted most recently
  always_comb begin
    grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
    grant_ifu = ifu_req_valid & (~lsu_req_valid | last_q);
    last_d    = hs ? grant_lsu : last_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid & ~lsu_req_valid;
  end
`endif

  // Ready is gated by reset so a held-high valid cannot leak through during reset.
  assign lsu_req_ready = (state_q == S_IDLE) & ~reset & grant_lsu;
  assign ifu_req_ready = (state_q == S_IDLE) & ~reset & grant_ifu;
  assign hs            = lsu_req_ready | ifu_req_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      S_IDLE: if (hs) begin
        state_d = S_REQ;
        owner_d = grant_lsu;
        addr_d  = grant_lsu ? lsu_addr : ifu_addr;
        wen_d   = grant_lsu & lsu_wen;
        wdata_d = grant_lsu ? lsu_wdata : '0;
        wmask_d = grant_lsu ? lsu_wmask : '0;
      end
      S_REQ:   if (mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign in_req        = (state_q == S_REQ);
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? addr_q  : '0;
  assign mem_wen       = in_req & wen_q;
  assign mem_wdata     = in_req ? wdata_q : '0;
  assign mem_wmask     = in_req ? wmask_q : '0;

  // Responses outside WAIT are stray and must not reach either requester.
  assign resp_fire      = (state_q == S_WAIT) & mem_resp_valid;
  assign ifu_resp_valid = resp_fire & ~owner_q;
  assign lsu_resp_valid = resp_fire & owner_q;
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
  assign busy           = (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written async-reset sequences.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        ifu_v;
    logic [31:0] ifu_a;
    logic        lsu_v;
    logic [31:0] lsu_a;
    logic        wen;
    logic [31:0] wd;
    logic [7:0]  wm;
    logic        mrdy;
    logic        mrv;
    logic [31:0] mrd;
  } in_t;

  typedef struct packed {
    logic        ifu_rdy;
    logic        lsu_rdy;
    logic        mem_v;
    logic [31:0] mem_a;
    logic        mem_wen;
    logic [31:0] mem_wd;
    logic [7:0]  mem_wm;
    logic        ifu_rv;
    logic [31:0] ifu_rd;
    logic        lsu_rv;
    logic [31:0] lsu_rd;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic iv, logic [31:0] ia, logic lv, logic [31:0] la, logic w,
                                logic [31:0] wd, logic [7:0] wm, logic mrdy, logic mrv, logic [31:0] mrd);
    in_t v;
    v.ifu_v = iv; v.ifu_a = ia; v.lsu_v = lv; v.lsu_a = la; v.wen = w;
    v.wd = wd; v.wm = wm; v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
    return v;
  endfunction

  function automatic out_t mk_out(logic ir, logic lr, logic mv, logic [31:0] ma, logic mw,
                                  logic [31:0] mwd, logic [7:0] mwm, logic irv, logic [31:0] ird,
                                  logic lrv, logic [31:0] lrd, logic b);
    out_t o;
    o.ifu_rdy = ir; o.lsu_rdy = lr; o.mem_v = mv; o.mem_a = ma; o.mem_wen = mw;
    o.mem_wd = mwd; o.mem_wm = mwm; o.ifu_rv = irv; o.ifu_rd = ird;
    o.lsu_rv = lrv; o.lsu_rd = lrd; o.busy = b;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wen = v.wen;
    lsu_wdata = v.wd; lsu_wmask = v.wm;
    mem_req_ready = v.mrdy; mem_resp_valid = v.mrv; mem_rdata = v.mrd;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
           ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata, busy};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    in_t  z_in;
    out_t z_out;
    bit   w;
    z_in  = '0;
    z_out = '0;

    // LSU store, memory stalls 3 cycles; stray response in REQ; IFU valid drops while busy.
    add(mk_in(0, 0, 1, 32'h80000100, 1, 32'hDEADBEEF, 8'h01, 0, 0, 0),
        mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99),
        mk_out(0, 0, 1, 32'h80000100, 1, 32'hDEADBEEF, 8'h01, 0, 0, 0, 0, 1));
    add(mk_in(1, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 0),
        mk_out(0, 0, 1, 32'h80000100, 1, 32'hDEADBEEF, 8'h01, 0, 0, 0, 0, 1));
    add(mk_in(1, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 0),
        mk_out(0, 0, 1, 32'h80000100, 1, 32'hDEADBEEF, 8'h01, 0, 0, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(0, 0, 1, 32'h80000100, 1, 32'hDEADBEEF, 8'h01, 0, 0, 0, 0, 1));
    add(z_in, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D),
        mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 1));
    add(z_in, z_out);

    // IFU fetch, response two cycles after the handshake; stray response in IDLE.
    add(mk_in(1, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
        mk_out(0, 0, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00100073),
        mk_out(0, 0, 0, 0, 0, 0, 0, 1, 32'h00100073, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555), z_out);

    // Both requesters held valid for four back-to-back transactions.
    for (int k = 0; k < 4; k++) begin
      w = RR ? (k % 2 == 0) : 1'b1;
      add(mk_in(1, 32'h1000, 1, 32'h2000, 0, 0, 8'h0F, 0, 0, 0),
          mk_out(~w, w, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(mk_in(1, 32'h1000, 1, 32'h2000, 0, 0, 8'h0F, 1, 0, 0),
          mk_out(0, 0, 1, w ? 32'h2000 : 32'h1000, 0, 0, w ? 8'h0F : 8'h00, 0, 0, 0, 0, 1));
      add(mk_in(1, 32'h1000, 1, 32'h2000, 0, 0, 8'h0F, 0, 1, 32'h100 + k),
          mk_out(0, 0, 0, 0, 0, 0, 0, ~w, w ? 32'h0 : 32'h100 + k, w, w ? 32'h100 + k : 32'h0, 1));
    end
    add(z_in, z_out);

    // Reset with every input active: all outputs must be 0.
    reset = 1'b1;
    drive(mk_in(1, 32'h44, 1, 32'h88, 1, 32'hFFFF, 8'hFF, 1, 1, 32'h1234));
    #2 check("reset_outputs", z_out);
    @(posedge clk); #1 check("reset_held_edge", z_out);
    @(negedge clk); reset = 1'b0; drive(z_in);
    #2 check("idle_after_reset", z_out);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].i);
      #2 check($sformatf("vec%0d", k), vecs[k].o);
    end

    // Reset pulsed asynchronously in WAIT, then a late response.
    @(negedge clk); drive(mk_in(1, 32'h3000, 0, 0, 0, 0, 0, 1, 0, 0));
    #2 check("wait_rst_hs", mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    #2 check("wait_rst_req", mk_out(0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk); drive(z_in);
    #2 check("wait_rst_wait", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #1 reset = 1'b1;
    #1 check("async_reset_in_wait", z_out);
    @(negedge clk); reset = 1'b0; drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD));
    #2 check("late_resp_ignored", z_out);

    // Back in IDLE: new handshake, then reset pulsed while in REQ.
    @(negedge clk); drive(mk_in(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 check("post_reset_hs", mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(z_in);
    #2 check("req_rst_req", mk_out(0, 0, 1, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 1));
    #1 reset = 1'b1;
    #1 check("async_reset_in_req", z_out);
    @(negedge clk); reset = 1'b0; drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77));
    #2 check("idle_after_req_reset", z_out);
    @(negedge clk); drive(z_in);
    #2 check("final_idle", z_out);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; MASK_W, 8, write-mask width.
REQ-002 Ports SHALL be, in order:
  clk  in  1  clock, rising edge;
  reset  in  1  asynchronous, active-high reset;
  ifu_req_valid  in  1  fetch request;
  ifu_req_ready  out  1  fetch request accepted;
  ifu_addr  in  ADDR_W  fetch address;
  ifu_resp_valid  out  1  fetch data valid;
  ifu_rdata  out  DATA_W  fetch data;
  lsu_req_valid  in  1  load/store request;
  lsu_req_ready  out  1  load/store accepted;
  lsu_addr  in  ADDR_W  load/store address;
  lsu_wen  in  1  1 = store;
  lsu_wdata  in  DATA_W  store data;
  lsu_wmask  in  MASK_W  store byte mask;
  lsu_resp_valid  out  1  load data or store acknowledge;
  lsu_rdata  out  DATA_W  load data;
  mem_req_valid  out  1  memory request;
  mem_req_ready  in  1  memory accepts request;
  mem_addr  out  ADDR_W;  mem_wen  out  1;  mem_wdata  out  DATA_W;  mem_wmask  out  MASK_W;
  mem_resp_valid  in  1  memory response;
  mem_rdata  in  DATA_W  memory read data;
  busy  out  1  a transaction is outstanding.

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ, WAIT; exactly one memory transaction SHALL be outstanding at a time.
REQ-004 In IDLE, the block SHALL assert ready combinationally to exactly one valid requester; a handshake is valid&ready in the same cycle.
REQ-005 On a handshake, the block SHALL latch the owner, addr, wen, wdata and wmask, and SHALL enter REQ. IFU requests SHALL latch wen=0 and wmask=0.
REQ-006 In REQ, mem_req_valid SHALL be 1 and the mem_* outputs SHALL come from the latched registers. The block SHALL enter WAIT on the first cycle with mem_req_ready=1.
REQ-007 In WAIT, when mem_resp_valid=1, the block SHALL assert the owner's resp_valid for exactly that cycle, with rdata=mem_rdata, and SHALL return to IDLE.
REQ-008 Stores SHALL complete only on mem_resp_valid; lsu_resp_valid SHALL signal the store acknowledge.
REQ-009 Outside WAIT, mem_resp_valid SHALL be ignored.
REQ-010 ifu_rdata and lsu_rdata SHALL be 0 whenever the matching resp_valid is 0.
REQ-011 Minimum latency: handshake at cycle N, mem_req_valid at N+1, resp_valid earliest at N+2, and the next handshake earliest at N+3.
REQ-012 Requester ready SHALL be 0 in REQ and WAIT; busy SHALL be 1 exactly in REQ and WAIT.
REQ-013 When both requesters are valid in the same cycle, the default priority SHALL be LSU over IFU.
REQ-014 Requests whose valid drops before a handshake SHALL be discarded without side effects.

Reset
REQ-015 Asserting reset SHALL immediately force IDLE, regardless of clk.
REQ-016 During reset, all outputs SHALL be 0 and the latched registers SHALL be 0.
REQ-017 A reset in REQ or WAIT SHALL abandon the transaction with no resp_valid issued.
REQ-018 With the round-robin feature, reset SHALL set last-granted to IFU.

Configuration
REQ-019 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on contention, the requester not granted most recently wins, and a one-bit last-granted register updates on every handshake.
REQ-020 Without MEM_ARB_RR_EN, arbitration SHALL be fixed LSU-first and no last-granted register SHALL exist.

Verification
REQ-021 Scenario: IFU only, addr 0x80000000, mem_req_ready=1, response 2 cycles later with rdata 0x00100073 -> mem_addr=0x80000000 for one cycle, then ifu_resp_valid for one cycle with ifu_rdata=0x00100073; LSU outputs stay 0.
REQ-022 Scenario: LSU store, addr 0x80000100, wdata 0xDEADBEEF, wmask 0x01, mem_req_ready held 0 for 3 cycles -> mem_req_valid held 4 cycles with stable fields, then lsu_resp_valid for one cycle on the acknowledge.
REQ-023 Scenario: IFU and LSU valid together for 4 transactions, default build -> LSU granted all 4 while IFU ready stays 0. With MEM_ARB_RR_EN -> grant order LSU, IFU, LSU, IFU.
REQ-024 Scenario: reset pulsed in WAIT before mem_resp_valid, then a late mem_resp_valid -> state IDLE, no resp_valid on either side, busy=0.
REQ-025 Scenario: mem_resp_valid=1 pulsed during IDLE and REQ -> ignored; no resp_valid, no state change.
